vx_tcu_drl_norm_round: RTL and testbench

Back end of the TCU dot-product datapath: accepts one signed fixed-point accumulator sum plus its window exponent, normalizes, rounds (RNE) and packs an IEEE FP32 result. It removes the window bias applied by the exponent-bias front end, so `raw_exp_y`-style exponents map back to FP32 biased exponents. It is a 3-stage elastic pipeline with valid/ready flow control and a pass-through tag.

---
 rtl/vx_tcu_drl_norm_round_pkg.sv | 23 ++
 rtl/vx_tcu_drl_norm_round_lzc.sv | 26 ++
 rtl/vx_tcu_drl_norm_round.sv | 198 +++++++++++++++++++
 tb/tb_vx_tcu_drl_norm_round.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_norm_round_pkg.sv
// Shared constants for the TCU dot-product back end.
//   F32_BIAS    : FP32 exponent bias
//   F32_QNAN    : canonical quiet NaN pattern
//   FFLAG_*     : bit positions inside the {NV, DZ, OF, UF, NX} flag vector
//   is_exp_neg_inf : recognises the window-exponent code that means
//                    "no contributing terms" (MSB set, all other bits clear)
package vx_tcu_drl_norm_round_pkg;

    localparam int          F32_BIAS = 127;
    localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    // exp_val carries the window exponent zero-extended to 16 bits.
    function automatic logic is_exp_neg_inf(input logic [15:0] exp_val, input int exp_w);
        return exp_val == (16'd1 << (exp_w - 1));
    endfunction

endpackage

// File: rtl/vx_tcu_drl_norm_round_lzc.sv
// Leading-zero counter.
//   data  : input vector
//   cnt   : number of zeros above the most significant one
//   valid : data contains at least one set bit (cnt is 0 otherwise)
module vx_tcu_drl_norm_round_lzc #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N)
) (
    input  logic [N-1:0]     data,
    output logic [CNT_W-1:0] cnt,
    output logic             valid
);

    // Ascending scan: the highest set bit is the last one to write cnt.
    always_comb begin
        cnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (data[i]) begin
                cnt   = CNT_W'(N - 1 - i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_tcu_drl_norm_round.sv
// Normalize / round / pack back end of the TCU dot-product datapath.
// Takes a signed fixed-point accumulator plus its window exponent and
// produces an FP32 result (RNE, flush-to-zero) through a 3-stage elastic
// pipeline with valid/ready flow control.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake
//   in_acc, in_exp         : signed mantissa sum and its window exponent
//   in_nan, in_inf, in_inf_sign : forced special results
//   in_tag                 : sideband carried to out_tag
//   out_valid / out_ready  : output handshake
//   out_result, out_fflags : FP32 result and {NV, DZ, OF, UF, NX}
//   out_tag                : tag matching out_result
module vx_tcu_drl_norm_round
    import vx_tcu_drl_norm_round_pkg::*;
#(
    parameter int WA    = 28,
    parameter int EXP_W = 10,
    parameter int ACC_W = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             in_inf_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_fflags
);

    localparam int LZ_W = $clog2(ACC_W);
    localparam int EW   = EXP_W + 2;
    localparam logic signed [EW-1:0] E_MAX  = EW'(255);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    typedef struct packed {
        logic             sign;
        logic [ACC_W-1:0] mag;
        logic [LZ_W-1:0]  lz;
        logic             is_zero;
        logic [EXP_W-1:0] exp;
        logic             nan;
        logic             inf;
        logic             inf_sign;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] e;
        logic [22:0]          mant;
        logic                 guard;
        logic                 sticky;
        logic                 is_zero;
        logic                 nan;
        logic                 inf;
        logic                 inf_sign;
        logic [TAG_W-1:0]     tag;
    } s2_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [4:0]       fflags;
        logic [TAG_W-1:0] tag;
    } s3_t;

    // Returns {carry_out, mantissa} after round-to-nearest-even.
    function automatic logic [23:0] round_rne(input logic [22:0] mant,
                                              input logic guard, input logic sticky);
        logic inc;
        inc = guard & (sticky | mant[0]);
        return {1'b0, mant} + 24'(inc);
    endfunction

    logic vld_p1, vld_p2, vld_p3;
    logic ld_p1, ld_p2, ld_p3;
    s1_t  beat_p1, nxt_p1;
    s2_t  beat_p2, nxt_p2;
    s3_t  beat_p3, nxt_p3;

    // Each stage loads when empty or when its contents move on this cycle.
    assign ld_p3    = !vld_p3 | out_ready;
    assign ld_p2    = !vld_p2 | ld_p3;
    assign ld_p1    = !vld_p1 | ld_p2;
    assign in_ready = ld_p1;

    // ---- stage 1: sign/magnitude and leading-one search ----
    logic [ACC_W-1:0] mag_c;
    logic [LZ_W-1:0]  lz_c;
    logic             lead_c;

    // The most-negative input negates to itself, which is its correct unsigned magnitude.
    assign mag_c = in_acc[ACC_W-1] ? (~in_acc + ACC_W'(1)) : in_acc;

    vx_tcu_drl_norm_round_lzc #(.N(ACC_W), .CNT_W(LZ_W)) lzc_i (
        .data  (mag_c),
        .cnt   (lz_c),
        .valid (lead_c)
    );

    always_comb begin
        nxt_p1          = '0;
        nxt_p1.sign     = in_acc[ACC_W-1];
        nxt_p1.mag      = mag_c;
        nxt_p1.lz       = lz_c;
        nxt_p1.is_zero  = !lead_c | is_exp_neg_inf(16'(in_exp), EXP_W);
        nxt_p1.exp      = in_exp;
        nxt_p1.nan      = in_nan;
        nxt_p1.inf      = in_inf;
        nxt_p1.inf_sign = in_inf_sign;
        nxt_p1.tag      = in_tag;
    end

    // ---- stage 2: exponent rebias and normalizing shift ----
    logic [LZ_W-1:0]  lead_pos_c;
    logic [ACC_W-2:0] frac_c;

    assign lead_pos_c = LZ_W'(ACC_W - 1) - beat_p1.lz;
    // The leading one lands at bit ACC_W-1 and is implicit, so it is dropped.
    assign frac_c     = (ACC_W-1)'(beat_p1.mag << beat_p1.lz);

    always_comb begin
        nxt_p2          = '0;
        nxt_p2.sign     = beat_p1.sign;
        nxt_p2.e        = {{2{beat_p1.exp[EXP_W-1]}}, beat_p1.exp}
                          + EW'(lead_pos_c) - EW'(WA - 1);
        nxt_p2.mant     = frac_c[ACC_W-2 -: 23];
        nxt_p2.guard    = frac_c[ACC_W-25];
        nxt_p2.sticky   = |frac_c[ACC_W-26:0];
        nxt_p2.is_zero  = beat_p1.is_zero;
        nxt_p2.nan      = beat_p1.nan;
        nxt_p2.inf      = beat_p1.inf;
        nxt_p2.inf_sign = beat_p1.inf_sign;
        nxt_p2.tag      = beat_p1.tag;
    end

    // ---- stage 3: round and pack ----
    logic [23:0]          rnd_c;
    logic signed [EW-1:0] e_rnd_c;

    assign rnd_c   = round_rne(beat_p2.mant, beat_p2.guard, beat_p2.sticky);
    assign e_rnd_c = beat_p2.e + EW'(rnd_c[23]);

    always_comb begin
        nxt_p3     = '0;
        nxt_p3.tag = beat_p2.tag;
        if (beat_p2.nan) begin
            nxt_p3.result = F32_QNAN;
        end else if (beat_p2.inf) begin
            nxt_p3.result = {beat_p2.inf_sign, 8'hFF, 23'd0};
        end else if (beat_p2.is_zero) begin
            nxt_p3.result = 32'd0;
        end else if (e_rnd_c >= E_MAX) begin
            nxt_p3.result           = {beat_p2.sign, 8'hFF, 23'd0};
            nxt_p3.fflags[FFLAG_OF] = 1'b1;
            nxt_p3.fflags[FFLAG_NX] = 1'b1;
        end else if (e_rnd_c <= E_ZERO) begin
            nxt_p3.result           = {beat_p2.sign, 31'd0};
            nxt_p3.fflags[FFLAG_UF] = 1'b1;
            nxt_p3.fflags[FFLAG_NX] = 1'b1;
        end else begin
            nxt_p3.result           = {beat_p2.sign, e_rnd_c[7:0], rnd_c[22:0]};
            nxt_p3.fflags[FFLAG_NX] = beat_p2.guard | beat_p2.sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (ld_p1) vld_p1 <= in_valid;
            if (ld_p2) vld_p2 <= vld_p1;
            if (ld_p3) vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p1) beat_p1 <= nxt_p1;
        if (ld_p2) beat_p2 <= nxt_p2;
        if (ld_p3) beat_p3 <= nxt_p3;
    end

    // Data registers are not reset; outputs are masked to zero while idle.
    assign out_valid  = vld_p3;
    assign out_result = vld_p3 ? beat_p3.result : 32'd0;
    assign out_tag    = vld_p3 ? beat_p3.tag    : '0;
    assign out_fflags = vld_p3 ? beat_p3.fflags : 5'd0;

endmodule

// File: tb/tb_vx_tcu_drl_norm_round.sv
module tb_vx_tcu_drl_norm_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [9:0]  in_exp;
    logic        in_nan;
    logic        in_inf;
    logic        in_inf_sign;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [7:0]  out_tag;
    logic [4:0]  out_fflags;

    int checks = 0;
    int errors = 0;

    vx_tcu_drl_norm_round #(.WA(28), .EXP_W(10), .ACC_W(32), .TAG_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .in_exp      (in_exp),
        .in_nan      (in_nan),
        .in_inf      (in_inf),
        .in_inf_sign (in_inf_sign),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_fflags  (out_fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] acc, input logic [9:0] exp, input logic nan,
                         input logic inf, input logic infs, input logic [7:0] tag);
        in_acc      = acc;
        in_exp      = exp;
        in_nan      = nan;
        in_inf      = inf;
        in_inf_sign = infs;
        in_tag      = tag;
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send(input logic [31:0] acc, input logic [9:0] exp, input logic nan,
                        input logic inf, input logic infs, input logic [7:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        drive(acc, exp, nan, inf, infs, tag);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] acc, input logic [9:0] exp,
                           input logic nan, input logic inf, input logic infs,
                           input logic [7:0] tag, input logic [31:0] res, input logic [4:0] ff);
        int lat;
        send(acc, exp, nan, inf, infs, tag);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd3);
        chk({name, "_res"}, out_result, res);
        chk({name, "_ff"}, 32'(out_fflags), 32'(ff));
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_exp [8];
    int          tx, rx, held, seen;
    logic        stall_prev;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(32'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_ff", 32'(out_fflags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values
        run_one("one",     32'h0800_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h11, 32'h3F80_0000, 5'b00000);
        run_one("negtie",  32'hEFFF_FFFF, 10'd127, 1'b0, 1'b0, 1'b0, 8'h12, 32'hC000_0000, 5'b00001);
        run_one("carry",   32'h0FFF_FFFF, 10'd127, 1'b0, 1'b0, 1'b0, 8'h13, 32'h4000_0000, 5'b00001);
        run_one("neg3",    32'hE800_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h14, 32'hC040_0000, 5'b00000);
        run_one("mostneg", 32'h8000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h15, 32'hC180_0000, 5'b00000);
        run_one("ovf",     32'h0800_0000, 10'd300, 1'b0, 1'b0, 1'b0, 8'h16, 32'h7F80_0000, 5'b00101);
        run_one("unf",     32'h0800_0000, 10'd0,   1'b0, 1'b0, 1'b0, 8'h17, 32'h0000_0000, 5'b00011);
        run_one("nan",     32'h0800_0000, 10'd127, 1'b1, 1'b0, 1'b0, 8'h18, 32'h7FC0_0000, 5'b00000);
        run_one("inf",     32'h0800_0000, 10'd127, 1'b0, 1'b1, 1'b1, 8'h19, 32'hFF80_0000, 5'b00000);
        run_one("zero",    32'h0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h1A, 32'h0000_0000, 5'b00000);
        run_one("neginf",  32'h0800_0000, 10'h200, 1'b0, 1'b0, 1'b0, 8'h1B, 32'h0000_0000, 5'b00000);

        // Back-pressure stream: beat k carries (k+1)*1.0 and tag k
        bp_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        tx = 0;
        rx = 0;
        stall_prev = 1'b0;
        for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 10) < 3;
            if (tx < 8) begin
                drive(32'(tx + 1) << 27, 10'd127, 1'b0, 1'b0, 1'b0, 8'(tx));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            held = tx - rx;
            if (stall_prev) chk("bp_hold_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk("bp_res", out_result, bp_exp[rx]);
                chk("bp_tag", 32'(out_tag), 32'(rx));
                if (out_ready) rx++;
            end
            if (in_valid && !in_ready) chk("bp_held", 32'(held), 32'd3);
            if (in_valid && in_ready) tx++;
            stall_prev = out_valid && !out_ready;
        end
        chk("bp_rx", 32'(rx), 32'd8);
        chk("bp_tx", 32'(tx), 32'd8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with three beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0800_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h21);
        send(32'h1000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h22);
        send(32'h1800_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h23);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_stale", 32'(seen), 32'd0);
        run_one("postrst", 32'h0800_0000, 10'd127, 1'b0, 1'b0, 1'b0, 8'h5A, 32'h3F80_0000, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
